vscpu_gen2: RTL and testbench
=============================

VSCPU_GEN2 -- requirements
Module: vscpu_gen2

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width of memory, PC and operand fields.
REQ-002 Parameter DATA_W, default 32: memory word and datapath width; DATA_W >= 2*ADDR_W+4 SHALL hold, enforced by an elaboration-time check.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 mem_rdata  in  DATA_W  read data, valid only in a cycle with mem_req=1, mem_we=0 and mem_ack=1.
REQ-006 mem_ack  in  1  completes the current access; may be high in the same cycle mem_req rises (zero-wait); ignored while mem_req=0.
REQ-007 mem_req  out  1  access request.
REQ-008 mem_we  out  1  1=write, 0=read; qualified by mem_req.
REQ-009 mem_addr  out  ADDR_W  access word address.
REQ-010 mem_wdata  out  DATA_W  write data; 0 when mem_we=0.
REQ-011 pc  out  ADDR_W  address of the current instruction.
REQ-012 retire  out  1  one-cycle pulse when an instruction completes.
REQ-013 halted  out  1  sticky halt indication.

Function
REQ-014 Instruction word fields: op=[DATA_W-1:DATA_W-3], imm=[DATA_W-4], A=[2*ADDR_W-1:ADDR_W], B=[ADDR_W-1:0]; other bits ignored.
REQ-015 Ops (imm=0 / imm=1): 000 ADD *A=*A+*B / *A=*A+B; 001 NAND *A=~(*A&*B) / ~(*A&B); 010 SRL / SRLi; 011 LT *A=(*A<*B) / (*A<B); 100 CP *A=*B / *A=B; 101 CPI *A=**B / CPIi **A=*B; 110 BZJ / BZJi; 111 MUL *A=*A**B / *A*B.
REQ-016 Immediate B is zero-extended to DATA_W; all compares unsigned; LT writes 1 or 0.
REQ-017 ADD and MUL keep the low DATA_W bits; overflow is discarded silently.
REQ-018 SRL, with shift amount s = *B (or B): if s < DATA_W, result = *A >> s; otherwise result = *A << (s-DATA_W), which is 0 when s >= 2*DATA_W.
REQ-019 BZJ: pc <= (*B==0) ? *A[ADDR_W-1:0] : pc+1. BZJi: pc <= (*A+B)[ADDR_W-1:0]. No write is performed.
REQ-020 Every other instruction sets pc <= pc+1, modulo 2^ADDR_W, so the PC wraps from max to 0.
REQ-021 States: FETCH, RD_A, RD_B, RD_IND, WRITE, HALT. Each non-HALT state issues exactly one access and stays in that state until mem_ack=1.
REQ-022 Access sequences:
- ALU reg ops: FETCH, RD_A, RD_B, WRITE.
- ALU imm ops: FETCH, RD_A, WRITE.
- CP: FETCH, RD_B, WRITE.
- CPi: FETCH, WRITE.
- CPI: FETCH, RD_B, RD_IND(addr=*B), WRITE(addr=A).
- CPIi: FETCH, RD_A, RD_B, WRITE(addr=*A).
- BZJ: FETCH, RD_A, RD_B.
- BZJi: FETCH, RD_A.
REQ-023 Indirect addresses use the low ADDR_W bits of the fetched data.
REQ-024 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable from request until ack; the next access may start the cycle after ack.
REQ-025 With zero-wait memory, a reg-op instruction takes 4 cycles; each wait cycle adds exactly 1 cycle.
REQ-026 retire pulses in the cycle after the final access's ack; pc updates on that same edge.
REQ-027 If a BZJ or BZJi computed target equals the current pc, the core enters HALT: halted=1, mem_req=0, pc frozen, until rst.
REQ-028 Unused opcode encodings do not exist, since all 16 are defined; the next instruction's FETCH follows retire with no gap.

Reset
REQ-029 While rst=1 (sampled at the clock edge), outputs are:
- state=FETCH, pc=0, halted=0, retire=0;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- all internal operand/data registers cleared.
REQ-030 rst mid-access abandons the access with no write committed; an ack during rst is ignored; FETCH at address 0 begins the first cycle after rst falls.

Verification
REQ-031 Zero-wait memory, mem[0]=ADD A=10,B=11, mem[10]=5, mem[11]=7 -> mem[10]=12 written in cycle 4, retire in cycle 5, pc=1.
REQ-032 Random 0-3 cycle ack delays on the same program -> identical memory results; mem_addr/mem_we/mem_wdata stable during every wait.
REQ-033 SRLi with *A=0x8000_0001: B=1 -> 0x4000_0000; B=33 -> 0x0000_0002; B=64 -> 0.
REQ-034 MUL with *A=0xFFFF_FFFF, *B=2 -> 0xFFFF_FFFE. LT with *A=3, *B=3 -> 0.
REQ-035 Program order CPI, then CPIi, then BZJ with *B=0 jumping to itself -> halted=1, mem_req stays 0, pc constant for 20 cycles.
REQ-036 rst asserted during a WRITE wait cycle, before ack -> target word unchanged; after release, a fetch from address 0 occurs.

Source files
------------

// File: rtl/vscpu_gen2.sv
// Multi-cycle very simple CPU: memory-to-memory ISA with eight ops, one memory
// access per state, sticky halt on a branch to itself.
module vscpu_gen2 #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic [2:0]        dbg_state
);

    generate
        if (DATA_W < 2 * ADDR_W + 4) begin : g_width_check
            $error("vscpu_gen2: DATA_W must be at least 2*ADDR_W+4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_RD_A   = 3'd1,
        S_RD_B   = 3'd2,
        S_RD_IND = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_CP   = 3'd4;
    localparam logic [2:0] OP_CPI  = 3'd5;
    localparam logic [2:0] OP_BZJ  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    localparam logic [DATA_W-1:0] DW_C  = DATA_W'(DATA_W);
    localparam logic [DATA_W-1:0] DW2_C = DATA_W'(2 * DATA_W);

    state_t            state;
    logic [2:0]        ir_op;
    logic              ir_imm;
    logic [ADDR_W-1:0] ir_a;
    logic [ADDR_W-1:0] ir_b;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] ind_val;

    logic [2:0]        rd_op;
    logic              rd_imm;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_tgt;
    logic              br_done;

    assign dbg_state = state;
    assign rd_op     = mem_rdata[DATA_W-1 -: 3];
    assign rd_imm    = mem_rdata[DATA_W-4];
    assign opnd      = ir_imm ? {{(DATA_W-ADDR_W){1'b0}}, ir_b} : b_val;
    assign pc_inc    = pc + ADDR_W'(1);

    // A branch finishes on the read that supplies its last operand: *A for BZJi, *B for BZJ.
    assign br_done = (ir_op == OP_BZJ) &&
                     ((state == S_RD_A && ir_imm) || (state == S_RD_B && !ir_imm));
    assign br_tgt  = ir_imm ? (mem_rdata[ADDR_W-1:0] + ir_b)
                            : ((mem_rdata == '0) ? a_val[ADDR_W-1:0] : pc_inc);

    always_comb begin
        result = '0;
        case (ir_op)
            OP_ADD:  result = a_val + opnd;
            OP_NAND: result = ~(a_val & opnd);
            OP_SRL: begin
                if (opnd < DW_C)       result = a_val >> opnd;
                else if (opnd < DW2_C) result = a_val << (opnd - DW_C);
                else                   result = '0;
            end
            OP_LT:   result = {{(DATA_W-1){1'b0}}, (a_val < opnd)};
            OP_CP:   result = opnd;
            OP_CPI:  result = ir_imm ? b_val : ind_val;
            OP_MUL:  result = a_val * opnd;
            default: result = '0;
        endcase
    end

    // Handshake: a request (mem_req with mem_we/mem_addr/mem_wdata) is held
    // unchanged from the cycle it appears until the cycle mem_ack=1; the
    // access completes on that edge and the next request may start right after.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                S_RD_A: begin
                    mem_req  = 1'b1;
                    mem_addr = ir_a;
                end
                S_RD_B: begin
                    mem_req  = 1'b1;
                    mem_addr = ir_b;
                end
                S_RD_IND: begin
                    mem_req  = 1'b1;
                    mem_addr = b_val[ADDR_W-1:0];
                end
                S_WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = (ir_op == OP_CPI && ir_imm) ? a_val[ADDR_W-1:0] : ir_a;
                    mem_wdata = result;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= '0;
            halted  <= 1'b0;
            retire  <= 1'b0;
            ir_op   <= '0;
            ir_imm  <= 1'b0;
            ir_a    <= '0;
            ir_b    <= '0;
            a_val   <= '0;
            b_val   <= '0;
            ind_val <= '0;
        end else begin
            retire <= 1'b0;
            if (state != S_HALT && mem_ack) begin
                case (state)
                    S_FETCH: begin
                        ir_op  <= rd_op;
                        ir_imm <= rd_imm;
                        ir_a   <= mem_rdata[2*ADDR_W-1:ADDR_W];
                        ir_b   <= mem_rdata[ADDR_W-1:0];
                        if (rd_op == OP_CP)                 state <= rd_imm ? S_WRITE : S_RD_B;
                        else if (rd_op == OP_CPI && !rd_imm) state <= S_RD_B;
                        else                                 state <= S_RD_A;
                    end
                    S_RD_A: begin
                        a_val <= mem_rdata;
                        if (br_done)                       state <= (br_tgt == pc) ? S_HALT : S_FETCH;
                        else if (ir_imm && ir_op != OP_CPI) state <= S_WRITE;
                        else                               state <= S_RD_B;
                    end
                    S_RD_B: begin
                        b_val <= mem_rdata;
                        if (br_done)                         state <= (br_tgt == pc) ? S_HALT : S_FETCH;
                        else if (ir_op == OP_CPI && !ir_imm) state <= S_RD_IND;
                        else                                 state <= S_WRITE;
                    end
                    S_RD_IND: begin
                        ind_val <= mem_rdata;
                        state   <= S_WRITE;
                    end
                    S_WRITE: begin
                        pc     <= pc_inc;
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end
                    default: state <= S_HALT;
                endcase
                if (br_done) begin
                    if (br_tgt == pc) begin
                        halted <= 1'b1;
                    end else begin
                        pc     <= br_tgt;
                        retire <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vscpu_gen2.sv
// Bench for vscpu_gen2: directed programs with known results plus random
// programs scored against an instruction-level model of the ISA.
module tb_vscpu_gen2;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int MEM_N = 1 << AW;
    localparam int EW    = 2 + AW + DW;
    localparam int N_INS = 150;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] pc;
    logic          retire;
    logic          halted;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    vscpu_gen2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pc(pc), .retire(retire), .halted(halted),
        .dbg_state(dbg_state)
    );

    logic [DW-1:0] mem     [MEM_N];
    logic [DW-1:0] ref_mem [MEM_N];
    logic [AW-1:0] ref_pc;
    bit            ref_halted;
    // Event entries: {kind, addr_or_pc, data}; kind 0=write, 1=retire(data=access count), 2=halt
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    int n_vec, n_err;
    int max_wait, wait_left, acks, idle, proto_err, cycle_no, ret_cnt, wr_cycle, ret_cycle;
    bit pend, block_writes, halt_seen;
    logic [AW-1:0] cap_addr;
    logic          cap_we;
    logic [DW-1:0] cap_wdata;

    function automatic logic [DW-1:0] enc(input int op, input int imm, input int a, input int b);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 3]     = op[2:0];
        w[DW-4]          = imm[0];
        w[2*AW-1 -: AW]  = a[AW-1:0];
        w[AW-1:0]        = b[AW-1:0];
        return w;
    endfunction

    // One clock of the memory responder; records writes, retires and halt as events.
    task automatic step();
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if (mem_req) begin
            if (!mem_we && mem_wdata !== '0) proto_err++;
            if (!pend) begin
                pend      = 1'b1;
                wait_left = int'($urandom_range(0, max_wait));
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                proto_err++;
            end
            if (mem_we && block_writes) begin
                wait_left = 0;
            end else if (wait_left == 0) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    got_q.push_back({2'd0, mem_addr, mem_wdata});
                    wr_cycle = cycle_no;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
                acks++;
                pend = 1'b0;
            end else begin
                wait_left--;
            end
        end else begin
            pend = 1'b0;
            if (!halted && !rst) idle++;
        end
        @(posedge clk);
        #1;
        cycle_no++;
        if (retire) begin
            got_q.push_back({2'd1, pc, DW'(acks)});
            acks      = 0;
            ret_cnt++;
            ret_cycle = cycle_no;
        end
        if (halted && !halt_seen) begin
            halt_seen = 1'b1;
            got_q.push_back({2'd2, pc, {DW{1'b0}}});
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 1'b0; acks = 0; idle = 0; proto_err = 0; cycle_no = 1;
        ret_cnt = 0; halt_seen = 1'b0; wr_cycle = -1; ret_cycle = -1;
        got_q.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_N; i++) mem[i] = '0;
    endtask

    task automatic run_to_halt(input int budget, output bit ok);
        for (int i = 0; i < budget && !halted; i++) step();
        ok = halted;
    endtask

    // Executes one whole instruction on ref_mem straight from the ISA rules.
    task automatic model_step();
        logic [DW-1:0] ins, va, vb, bop, wval;
        logic [2:0]    op;
        logic          imm;
        logic [AW-1:0] fa, fb, waddr, tgt;
        int            nacc;
        bit            wr;
        ins  = ref_mem[ref_pc];
        op   = ins[DW-1 -: 3];
        imm  = ins[DW-4];
        fa   = ins[2*AW-1 -: AW];
        fb   = ins[AW-1:0];
        va   = ref_mem[fa];
        vb   = ref_mem[fb];
        bop  = imm ? DW'(fb) : vb;
        wr   = 1'b1;
        waddr = fa;
        wval = '0;
        tgt  = ref_pc + AW'(1);
        nacc = imm ? 3 : 4;
        case (op)
            3'd0: wval = va + bop;
            3'd1: wval = ~(va & bop);
            3'd2: begin
                if (bop < 32)      wval = va >> bop;
                else if (bop < 64) wval = va << (bop - 32);
                else               wval = '0;
            end
            3'd3: wval = (va < bop) ? DW'(1) : DW'(0);
            3'd4: begin wval = bop; nacc = imm ? 2 : 3; end
            3'd5: begin
                nacc = 4;
                if (imm) begin waddr = va[AW-1:0]; wval = vb; end
                else wval = ref_mem[vb[AW-1:0]];
            end
            3'd6: begin
                wr   = 1'b0;
                nacc = imm ? 2 : 3;
                if (imm) tgt = va[AW-1:0] + fb;
                else if (vb == '0) tgt = va[AW-1:0];
            end
            default: wval = va * bop;
        endcase
        if (tgt == ref_pc) begin
            ref_halted = 1'b1;
            exp_q.push_back({2'd2, ref_pc, {DW{1'b0}}});
        end else begin
            if (wr) begin
                ref_mem[waddr] = wval;
                exp_q.push_back({2'd0, waddr, wval});
            end
            ref_pc = tgt;
            exp_q.push_back({2'd1, ref_pc, DW'(nacc)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (pc !== '0)      begin n_err++; $display("FAIL reset_pc got=%h exp=0", pc); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_vec++; if (retire !== 1'b0) begin n_err++; $display("FAIL reset_retire got=%b exp=0", retire); end
        n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0)
            begin n_err++; $display("FAIL reset_req_we got=%b%b exp=00", mem_req, mem_we); end
        n_vec++; if (mem_addr !== '0 || mem_wdata !== '0)
            begin n_err++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_add_timing();
        clear_mem();
        mem[0] = enc(0, 0, 10, 11); mem[10] = 5; mem[11] = 7;
        max_wait = 0; block_writes = 1'b0;
        do_reset();
        repeat (4) step();
        n_vec++; if (mem[10] !== 32'd12) begin n_err++; $display("FAIL add_result got=%0d exp=12", mem[10]); end
        n_vec++; if (wr_cycle != 4) begin n_err++; $display("FAIL add_write_cycle got=%0d exp=4", wr_cycle); end
        n_vec++; if (ret_cycle != 5) begin n_err++; $display("FAIL add_retire_cycle got=%0d exp=5", ret_cycle); end
        n_vec++; if (pc !== 14'd1) begin n_err++; $display("FAIL add_pc got=%0d exp=1", pc); end
        n_vec++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'd1)
            begin n_err++; $display("FAIL add_next_fetch got=%b%b@%0d exp=10@1", mem_req, mem_we, mem_addr); end
    endtask

    task automatic test_random_delay();
        for (int r = 0; r < 4; r++) begin
            clear_mem();
            mem[0] = enc(0, 0, 10, 11); mem[10] = 5; mem[11] = 7;
            max_wait = 3; block_writes = 1'b0;
            do_reset();
            for (int i = 0; i < 40 && ret_cnt == 0; i++) step();
            n_vec++; if (ret_cnt != 1) begin n_err++; $display("FAIL delay_retire r=%0d got=%0d exp=1", r, ret_cnt); end
            n_vec++; if (mem[10] !== 32'd12) begin n_err++; $display("FAIL delay_result r=%0d got=%0d exp=12", r, mem[10]); end
            n_vec++; if (pc !== 14'd1) begin n_err++; $display("FAIL delay_pc r=%0d got=%0d exp=1", r, pc); end
            n_vec++; if (proto_err != 0) begin n_err++; $display("FAIL delay_stable r=%0d got=%0d exp=0", r, proto_err); end
        end
    endtask

    task automatic test_srl();
        bit ok;
        clear_mem();
        mem[0] = enc(2, 1, 20, 1); mem[1] = enc(2, 1, 21, 33); mem[2] = enc(2, 1, 22, 64);
        mem[3] = enc(6, 1, 23, 3);
        mem[20] = 32'h8000_0001; mem[21] = 32'h8000_0001; mem[22] = 32'h8000_0001;
        max_wait = 2; block_writes = 1'b0;
        do_reset();
        run_to_halt(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL srl_halt got=%b exp=1", halted); end
        n_vec++; if (mem[20] !== 32'h4000_0000) begin n_err++; $display("FAIL srl_b1 got=%h exp=40000000", mem[20]); end
        n_vec++; if (mem[21] !== 32'h0000_0002) begin n_err++; $display("FAIL srl_b33 got=%h exp=00000002", mem[21]); end
        n_vec++; if (mem[22] !== 32'h0000_0000) begin n_err++; $display("FAIL srl_b64 got=%h exp=00000000", mem[22]); end
    endtask

    task automatic test_mul_lt();
        bit ok;
        clear_mem();
        mem[0] = enc(7, 0, 20, 21); mem[1] = enc(3, 0, 22, 23); mem[2] = enc(3, 0, 25, 23);
        mem[3] = enc(6, 1, 24, 3);
        mem[20] = 32'hFFFF_FFFF; mem[21] = 2; mem[22] = 3; mem[23] = 3; mem[25] = 2;
        max_wait = 1; block_writes = 1'b0;
        do_reset();
        run_to_halt(100, ok);
        n_vec++; if (!ok || pc !== 14'd3) begin n_err++; $display("FAIL mullt_halt got=%b@%0d exp=1@3", halted, pc); end
        n_vec++; if (mem[20] !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mul_wrap got=%h exp=fffffffe", mem[20]); end
        n_vec++; if (mem[22] !== 32'd0) begin n_err++; $display("FAIL lt_equal got=%h exp=0", mem[22]); end
        n_vec++; if (mem[25] !== 32'd1) begin n_err++; $display("FAIL lt_less got=%h exp=1", mem[25]); end
    endtask

    task automatic test_cpi_halt();
        bit ok;
        clear_mem();
        mem[0] = enc(5, 0, 30, 31); mem[1] = enc(5, 1, 32, 33); mem[2] = enc(6, 0, 34, 35);
        mem[31] = 40; mem[40] = 32'hDEAD; mem[32] = 50; mem[33] = 32'hBEEF; mem[34] = 2;
        max_wait = 2; block_writes = 1'b0;
        do_reset();
        run_to_halt(100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL cpi_halt got=%b exp=1", halted); end
        n_vec++; if (mem[30] !== 32'hDEAD) begin n_err++; $display("FAIL cpi_ind got=%h exp=dead", mem[30]); end
        n_vec++; if (mem[50] !== 32'hBEEF) begin n_err++; $display("FAIL cpii_ind got=%h exp=beef", mem[50]); end
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 14'd2) begin
                n_err++;
                $display("FAIL halt_hold c=%0d got=h%b r%b pc%0d exp=h1 r0 pc2", i, halted, mem_req, pc);
            end
        end
    endtask

    task automatic test_rst_write();
        clear_mem();
        mem[0] = enc(0, 0, 10, 11); mem[10] = 5; mem[11] = 7;
        max_wait = 0; block_writes = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && !(mem_req && mem_we); i++) step();
        step(); step();
        n_vec++; if (mem_we !== 1'b1 || mem_addr !== 14'd10)
            begin n_err++; $display("FAIL rstw_in_write got=%b@%0d exp=1@10", mem_we, mem_addr); end
        rst = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstw_req_drop got=%b exp=0", mem_req); end
        step(); step();
        n_vec++; if (mem[10] !== 32'd5) begin n_err++; $display("FAIL rstw_no_commit got=%0d exp=5", mem[10]); end
        n_vec++; if (pc !== '0 || retire !== 1'b0) begin n_err++; $display("FAIL rstw_state got=%0d/%b exp=0/0", pc, retire); end
        rst = 1'b0; block_writes = 1'b0;
        pend = 1'b0; acks = 0; ret_cnt = 0; cycle_no = 1;
        #1;
        n_vec++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0)
            begin n_err++; $display("FAIL rstw_fetch0 got=%b%b@%0d exp=10@0", mem_req, mem_we, mem_addr); end
        for (int i = 0; i < 20 && ret_cnt == 0; i++) step();
        n_vec++; if (mem[10] !== 32'd12) begin n_err++; $display("FAIL rstw_rerun got=%0d exp=12", mem[10]); end
    endtask

    task automatic test_random_program();
        logic [DW-1:0] v, g, e;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < MEM_N; i++) begin
                v = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 70)) : DW'($urandom);
                mem[i] = v;
                ref_mem[i] = v;
            end
            exp_q.delete();
            ref_pc = '0; ref_halted = 1'b0;
            for (int n = 0; n < N_INS && !ref_halted; n++) model_step();
            max_wait = (r == 0) ? 0 : 3; block_writes = 1'b0;
            do_reset();
            for (int c = 0; c < N_INS * 20 && ret_cnt < N_INS && !halted; c++) step();
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra_event r=%0d got=%h exp=none", r, g);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin n_err++; $display("FAIL rand_event r=%0d got=%h exp=%h", r, g, e); end
                end
            end
            n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_missing r=%0d got=%0d exp=0", r, exp_q.size()); end
            n_vec++; if (proto_err != 0) begin n_err++; $display("FAIL rand_stable r=%0d got=%0d exp=0", r, proto_err); end
            n_vec++; if (idle != 0) begin n_err++; $display("FAIL rand_gap r=%0d got=%0d exp=0", r, idle); end
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        n_vec = 0; n_err = 0; max_wait = 0; block_writes = 1'b0;
        pend = 1'b0; halt_seen = 1'b0; acks = 0; idle = 0; proto_err = 0;
        cycle_no = 0; ret_cnt = 0; wait_left = 0; wr_cycle = -1; ret_cycle = -1;
        test_reset();
        test_add_timing();
        test_random_delay();
        test_srl();
        test_mul_lt();
        test_cpi_halt();
        test_rst_write();
        test_random_program();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
